// File: rtl/reset_sequencer.sv
// Reset sequencer for the 42 MHz PLL domain: synchronizes PLL lock and the reset
// button, debounces the button, and releases sysReset only after lock is stable.
module reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 64,
  parameter int DEBOUNCE_CYCLES    = 4200,
  parameter int CNT_WIDTH          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       isLocked,
  input  logic       extReset,
  output logic       sysReset,
  output logic       ready,
  output logic [7:0] lockLostCount,
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   lock_s;
  logic                   btn_s;

  logic [CNT_WIDTH-1:0]   deb_cnt_q, deb_cnt_d;
  logic                   btn_deb_q, btn_deb_d;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [7:0]             lost_q, lost_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   ready_q, ready_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], isLocked};
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], extReset};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign btn_s  = btn_sync_q[SYNC_STAGES-1];

  // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_cnt_d = '0;
    btn_deb_d = btn_deb_q;
    if (btn_s != btn_deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_deb_d = ~btn_deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = CNT_ONE;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (btn_deb_q) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        // Lock loss is checked first so it wins over a simultaneous button press.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          if (lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
          end
        end else if (btn_deb_q) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_q   <= '0;
      btn_deb_q   <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      lost_q      <= '0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      btn_deb_q   <= btn_deb_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lost_q      <= lost_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
    end
  end

  assign sysReset      = sys_reset_q;
  assign ready         = ready_q;
  assign lockLostCount = lost_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed power-up/lock/button/reset steps plus random
// traffic, checked against a streak-based model of the release rules.
module tb_reset_sequencer;

  localparam int S  = 2;
  localparam int L  = 16;
  localparam int H  = 8;
  localparam int D  = 4;
  localparam int CW = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       isLocked;
  logic       extReset;
  logic       sysReset;
  logic       ready;
  logic [7:0] lockLostCount;
  logic [1:0] state_dbg;

  int tests  = 0;
  int failed = 0;

  reset_sequencer #(
    .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .HOLD_CYCLES(H),
    .DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .isLocked(isLocked), .extReset(extReset),
    .sysReset(sysReset), .ready(ready), .lockLostCount(lockLostCount),
    .state_dbg_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference model: release needs a lock streak of L+H synchronized samples and
  // the last H debounced samples quiet; the button level moves after D disagreements.
  logic [9:0] exp_q[$];
  bit m_lq[$];
  bit m_bq[$];
  bit m_btnd;
  bit m_run;
  int m_mis, m_streak, m_quiet, m_lost;

  task automatic model_reset();
    m_lq.delete();
    m_bq.delete();
    for (int i = 0; i < S; i++) begin
      m_lq.push_back(1'b0);
      m_bq.push_back(1'b0);
    end
    m_btnd = 1'b0; m_run = 1'b0;
    m_mis = 0; m_streak = 0; m_quiet = 0; m_lost = 0;
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, 8'd0});
  endtask

  task automatic model_step();
    bit ls, bs, bd_old, run_new;
    ls = m_lq.pop_front(); m_lq.push_back(isLocked);
    bs = m_bq.pop_front(); m_bq.push_back(extReset);
    bd_old = m_btnd;
    if (bs != m_btnd) begin
      m_mis++;
      if (m_mis == D) begin
        m_btnd = bs;
        m_mis  = 0;
      end
    end else begin
      m_mis = 0;
    end
    m_streak = ls ? ((m_streak < 100000) ? m_streak + 1 : m_streak) : 0;
    m_quiet  = bd_old ? 0 : ((m_quiet < 100000) ? m_quiet + 1 : m_quiet);
    run_new  = (m_streak >= L + H) && (m_quiet >= H);
    if (m_run && !ls && m_lost < 255) m_lost++;
    m_run = run_new;
    exp_q.push_back({!m_run, m_run, 8'(m_lost)});
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // scoreboard
  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [9:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
    chk(tag, {sysReset, ready, lockLostCount}, e);
  endtask

  // driver tasks
  task automatic step(input string tag);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step("in_reset");
    reset = 1'b0;
  endtask

  task automatic power_up_check(input string tag);
    for (int e = 1; e <= 30; e++) begin
      step(tag);
      if (e == 25) chk({tag, "_e25_sys"}, 10'(sysReset), 10'd1);
      if (e == 26) begin
        chk({tag, "_e26_sys"}, 10'(sysReset), 10'd0);
        chk({tag, "_e26_ready"}, 10'(ready), 10'd1);
        chk({tag, "_e26_lost"}, 10'(lockLostCount), 10'd0);
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; isLocked = 1'b0; extReset = 1'b0;
    #1 reset = 1'b1;
    step("reset_state");
    chk("reset_sys", 10'(sysReset), 10'd1);
    chk("reset_lost", 10'(lockLostCount), 10'd0);

    // power-up
    isLocked = 1'b1;
    do_reset();
    power_up_check("pwr");

    // one-cycle lock glitch while counting stable time
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      step("glitch");
      if (e == 35) chk("glitch_e35_sys", 10'(sysReset), 10'd1);
      if (e == 36) chk("glitch_e36_sys", 10'(sysReset), 10'd0);
      if (e == 9)  isLocked = 1'b0;
      if (e == 10) isLocked = 1'b1;
    end
    chk("glitch_lost", 10'(lockLostCount), 10'd0);

    // lock loss in RUN
    isLocked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step("loss");
      chk("loss_sys", 10'(sysReset), (e == 3) ? 10'd1 : 10'd0);
    end
    chk("loss_ready", 10'(ready), 10'd0);
    chk("loss_lost", 10'(lockLostCount), 10'd1);
    isLocked = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      step("relock");
      if (e == 25) chk("relock_e25_sys", 10'(sysReset), 10'd1);
      if (e == 26) chk("relock_e26_sys", 10'(sysReset), 10'd0);
    end

    // 300 more losses to reach saturation
    for (int i = 0; i < 300; i++) begin
      isLocked = 1'b0;
      n = $urandom_range(1, 4);
      repeat (n) step("sat_drop");
      isLocked = 1'b1;
      n = 26 + $urandom_range(0, 3);
      repeat (n) step("sat_relock");
    end
    chk("sat_lost", 10'(lockLostCount), 10'd255);
    chk("sat_ready", 10'(ready), 10'd1);

    // bounce shorter than the debounce time
    extReset = 1'b1;
    repeat (3) step("bounce");
    extReset = 1'b0;
    repeat (15) begin
      step("bounce_after");
      chk("bounce_sys", 10'(sysReset), 10'd0);
    end

    // clean press of 20 cycles
    extReset = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step("press");
      chk("press_sys", 10'(sysReset), (e >= 7) ? 10'd1 : 10'd0);
    end
    extReset = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      step("release");
      chk("release_sys", 10'(sysReset), (e == 14) ? 10'd0 : 10'd1);
    end
    chk("release_ready", 10'(ready), 10'd1);

    // random lock drops, button pulses and idle spans
    for (int seg = 0; seg < 80; seg++) begin
      case ($urandom_range(0, 2))
        0: begin
          isLocked = 1'b0;
          n = $urandom_range(1, 30);
          repeat (n) step("rnd_lock");
          isLocked = 1'b1;
        end
        1: begin
          extReset = 1'b1;
          n = $urandom_range(1, 12);
          repeat (n) step("rnd_btn");
          extReset = 1'b0;
        end
        default: begin
          n = $urandom_range(1, 40);
          repeat (n) step("rnd_idle");
        end
      endcase
    end

    // async reset in the middle of RUN
    isLocked = 1'b1; extReset = 1'b0;
    repeat (40) step("pre_async");
    chk("pre_async_ready", 10'(ready), 10'd1);
    chk("pre_async_lost", 10'(lockLostCount), 10'd255);
    #2 reset = 1'b1;
    #1;
    chk("async_sys", 10'(sysReset), 10'd1);
    chk("async_ready", 10'(ready), 10'd0);
    chk("async_lost", 10'(lockLostCount), 10'd0);
    check_model("async_model");
    step("async_hold");
    reset = 1'b0;
    power_up_check("repwr");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
